// File: rtl/rv32i_mtimer_if.sv
// Halfword memory-port bundle between the core's region mux and the machine timer.
interface rv32i_mtimer_if;
    logic        select_i;
    logic        read_i;
    logic        write_i;
    logic [3:0]  addr_i;
    logic [15:0] data_i;
    logic [15:0] write_mask_i;
    logic [15:0] data_o;

    modport master (
        output select_i, read_i, write_i, addr_i, data_i, write_mask_i,
        input  data_o
    );

    modport slave (
        input  select_i, read_i, write_i, addr_i, data_i, write_mask_i,
        output data_o
    );
endinterface

// File: rtl/rv32i_mtimer.sv
// Machine timer: 64-bit mtime / mtimecmp behind four halfword registers each,
// a prescaled count enable and a level timer interrupt. Reads are registered with
// one-cycle latency, like the block RAMs sharing the same port.
module rv32i_mtimer #(
    parameter int PORT_LEN      = 16,
    parameter int PRESCALE_BITS = 8
) (
    input  logic           clk_i,
    input  logic           reset_ni,
    rv32i_mtimer_if.slave  bus,
    output logic           irq_o
);

    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic                     en_q, en_d;
    logic                     irqEn_q, irqEn_d;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [PRESCALE_BITS-1:0] preCnt_q, preCnt_d;
    logic [47:0]              snap_q, snap_d;
    logic [PORT_LEN-1:0]      data_q, data_d;
    logic                     irq_q, irq_d;

    logic        doRead;
    logic        doWrite;
    logic        tick;
    logic        cmpHit;
    logic [5:0]  hwBase;
    logic [15:0] ctrlRd;
    logic [15:0] statusRd;
    logic [15:0] rdVal;
    logic [15:0] mask;

    // Bus decode, prescaler tick, register read mux and all next-state values.
    always_comb begin
        doRead     = bus.select_i & bus.read_i;
        doWrite    = bus.select_i & bus.write_i;
        mask       = bus.write_mask_i;
        hwBase     = {bus.addr_i[1:0], 4'b0000};
        tick       = en_q && (preCnt_q == prescale_q);
        cmpHit     = (mtime_q >= mtimecmp_q);

        ctrlRd                      = '0;
        ctrlRd[0]                   = en_q;
        ctrlRd[1]                   = irqEn_q;
        ctrlRd[8 +: PRESCALE_BITS]  = prescale_q;

        statusRd    = '0;
        statusRd[0] = cmpHit;
        statusRd[1] = en_q;

        unique case (bus.addr_i)
            4'd0:    rdVal = mtime_q[15:0];
            4'd1:    rdVal = snap_q[15:0];
            4'd2:    rdVal = snap_q[31:16];
            4'd3:    rdVal = snap_q[47:32];
            4'd4:    rdVal = mtimecmp_q[15:0];
            4'd5:    rdVal = mtimecmp_q[31:16];
            4'd6:    rdVal = mtimecmp_q[47:32];
            4'd7:    rdVal = mtimecmp_q[63:48];
            4'd8:    rdVal = ctrlRd;
            4'd9:    rdVal = statusRd;
            default: rdVal = '0;
        endcase

        mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        irqEn_d    = irqEn_q;
        prescale_d = prescale_q;
        snap_d     = snap_q;
        data_d     = data_q;
        irq_d      = irqEn_q & cmpHit;

        if (tick) begin
            preCnt_d = '0;
        end else if (en_q) begin
            preCnt_d = preCnt_q + 1'b1;
        end else begin
            preCnt_d = preCnt_q;
        end

        if (doRead) begin
            data_d = rdVal;
            if (bus.addr_i == 4'd0) begin
                snap_d = mtime_q[63:16];
            end
        end

        if (doWrite) begin
            if (bus.addr_i[3:2] == 2'b00) begin
                // A software load wins over a tick: start from the un-ticked value.
                mtime_d = mtime_q;
                mtime_d[hwBase +: 16] = (mtime_q[hwBase +: 16] & ~mask) | (bus.data_i & mask);
            end else if (bus.addr_i[3:2] == 2'b01) begin
                mtimecmp_d[hwBase +: 16] = (mtimecmp_q[hwBase +: 16] & ~mask) | (bus.data_i & mask);
            end else if (bus.addr_i == 4'd8) begin
                en_d       = (en_q & ~mask[0]) | (bus.data_i[0] & mask[0]);
                irqEn_d    = (irqEn_q & ~mask[1]) | (bus.data_i[1] & mask[1]);
                prescale_d = (prescale_q & ~mask[8 +: PRESCALE_BITS])
                           | (bus.data_i[8 +: PRESCALE_BITS] & mask[8 +: PRESCALE_BITS]);
                preCnt_d   = '0;
            end
        end
    end

    // State registers; reset parks mtimecmp at all-ones so no interrupt can fire early.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            irqEn_q    <= 1'b0;
            prescale_q <= '0;
            preCnt_q   <= '0;
            snap_q     <= '0;
            data_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            irqEn_q    <= irqEn_d;
            prescale_q <= prescale_d;
            preCnt_q   <= preCnt_d;
            snap_q     <= snap_d;
            data_q     <= data_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.data_o = data_q[15:0];
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_rv32i_mtimer.sv
// Self-checking bench for rv32i_mtimer: directed test-plan steps followed by a
// randomized phase, all checked every cycle against a behavioural timer model.
module tb_rv32i_mtimer;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic irq_o;

    rv32i_mtimer_if bus ();

    rv32i_mtimer #(.PORT_LEN(16), .PRESCALE_BITS(8)) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bus.slave),
        .irq_o    (irq_o)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    string stepTag = "init";

    // Behavioural model of the programmer-visible timer state.
    bit [63:0]   mTime;
    bit [63:0]   mCmp;
    bit          mEn;
    bit          mIrqEn;
    int unsigned mPre;
    int unsigned mPhase;
    bit [63:0]   mSnap;
    bit [15:0]   expData;
    bit          expIrq;

    function automatic bit [15:0] merge16(bit [15:0] old, bit [15:0] d, bit [15:0] m);
        return (old & ~m) | (d & m);
    endfunction

    task automatic modelReset();
        mTime = 64'd0; mCmp = ~64'd0; mEn = 0; mIrqEn = 0;
        mPre = 0; mPhase = 0; mSnap = 64'd0; expData = 16'h0; expIrq = 0;
    endtask

    // One clock edge of the timer, from the register-map rules.
    task automatic modelEdge(input bit sel, input bit rd, input bit wr,
                             input bit [3:0] a, input bit [15:0] d, input bit [15:0] m);
        bit        ticked;
        bit [63:0] newTime;
        bit [15:0] ctrlVal;
        int        hw;
        ticked  = mEn && (mPhase == mPre);
        ctrlVal = {mPre[7:0], 6'b0, mIrqEn, mEn};
        expIrq  = mIrqEn && (mTime >= mCmp);
        if (sel && rd) begin
            if (a == 0) begin
                expData = mTime[15:0];
                mSnap   = mTime >> 16;
            end else if (a <= 3) begin
                hw = int'(a);
                expData = mSnap[16*(hw-1) +: 16];
            end else if (a <= 7) begin
                hw = int'(a) - 4;
                expData = mCmp[16*hw +: 16];
            end else if (a == 8) begin
                expData = ctrlVal;
            end else if (a == 9) begin
                expData = {14'b0, mEn, (mTime >= mCmp)};
            end else begin
                expData = 16'h0;
            end
        end
        newTime = ticked ? mTime + 64'd1 : mTime;
        if (mEn) mPhase = ticked ? 0 : mPhase + 1;
        if (sel && wr) begin
            if (a <= 3) begin
                hw = int'(a);
                newTime = mTime;
                newTime[16*hw +: 16] = merge16(mTime[16*hw +: 16], d, m);
            end else if (a <= 7) begin
                hw = int'(a) - 4;
                mCmp[16*hw +: 16] = merge16(mCmp[16*hw +: 16], d, m);
            end else if (a == 8) begin
                ctrlVal = merge16(ctrlVal, d, m);
                mEn     = ctrlVal[0];
                mIrqEn  = ctrlVal[1];
                mPre    = int'(ctrlVal[15:8]);
                mPhase  = 0;
            end
        end
        mTime = newTime;
    endtask

    task automatic checkOutput(input string tag);
        compared++;
        assert (bus.data_o === expData) else begin
            mismatched++;
            $error("[TB] FAIL %s data_o: got %h expected %h", tag, bus.data_o, expData);
        end
        compared++;
        assert (irq_o === expIrq) else begin
            mismatched++;
            $error("[TB] FAIL %s irq_o: got %b expected %b", tag, irq_o, expIrq);
        end
    endtask

    task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drive one bus cycle, let the edge happen, then compare against the model.
    task automatic applyStimulus(input bit sel, input bit rd, input bit wr,
                                 input bit [3:0] a, input bit [15:0] d, input bit [15:0] m);
        bus.select_i     = sel;
        bus.read_i       = rd;
        bus.write_i      = wr;
        bus.addr_i       = a;
        bus.data_i       = d;
        bus.write_mask_i = m;
        @(posedge clk);
        modelEdge(sel, rd, wr, a, d, m);
        #1;
        checkOutput(stepTag);
    endtask

    task automatic wrReg(input bit [3:0] a, input bit [15:0] d);
        applyStimulus(1, 0, 1, a, d, 16'hFFFF);
    endtask

    task automatic rdReg(input bit [3:0] a);
        applyStimulus(1, 1, 0, a, 16'h0, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 4'd0, 16'h0, 16'h0);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without waiting for a clock.
    task automatic pulseReset(input string tag);
        #2 reset_ni = 1'b0;
        #1;
        checkValue({tag, " data_o async"}, bus.data_o, 16'h0000);
        checkValue({tag, " irq_o async"}, {15'b0, irq_o}, 16'h0000);
        modelReset();
        #1 reset_ni = 1'b1;
    endtask

    initial begin
        bit [3:0]  a;
        bit [15:0] d;
        bit [15:0] m;
        bit        sel, rd, wr;

        bus.select_i = 0; bus.read_i = 0; bus.write_i = 0;
        bus.addr_i = '0; bus.data_i = '0; bus.write_mask_i = '0;
        modelReset();
        #3;
        checkValue("power-on data_o", bus.data_o, 16'h0000);
        #9 reset_ni = 1'b1;

        // Reset while counting with the interrupt asserted.
        stepTag = "reset";
        wrReg(4'd4, 16'h0); wrReg(4'd5, 16'h0); wrReg(4'd6, 16'h0); wrReg(4'd7, 16'h0);
        wrReg(4'd8, 16'h0003);
        idle(5);
        rdReg(4'd0);
        checkValue("irq before reset", {15'b0, irq_o}, 16'h0001);
        pulseReset("reset");
        rdReg(4'd0);
        checkValue("mtime lo after reset", bus.data_o, 16'h0000);
        rdReg(4'd4);
        checkValue("mtimecmp lo after reset", bus.data_o, 16'hFFFF);

        // Basic count, prescale 0 then prescale 3.
        stepTag = "count";
        wrReg(4'd8, 16'h0001);
        idle(9);
        rdReg(4'd0);
        checkValue("count presc0", bus.data_o, 16'h0009);
        wrReg(4'd8, 16'h0000);
        wrReg(4'd0, 16'h0); wrReg(4'd1, 16'h0); wrReg(4'd2, 16'h0); wrReg(4'd3, 16'h0);
        wrReg(4'd8, 16'h0301);
        idle(40);
        rdReg(4'd0);
        checkValue("count presc3", bus.data_o, 16'h000A);

        // Snapshot keeps the upper halfwords coherent with the low read.
        stepTag = "snapshot";
        wrReg(4'd8, 16'h0000);
        wrReg(4'd0, 16'hFFFE); wrReg(4'd1, 16'h0); wrReg(4'd2, 16'h0); wrReg(4'd3, 16'h0);
        wrReg(4'd8, 16'h0001);
        rdReg(4'd0);
        checkValue("snap lo", bus.data_o, 16'hFFFE);
        idle(4);
        rdReg(4'd1);
        checkValue("snap hi", bus.data_o, 16'h0000);
        rdReg(4'd0);

        // Compare and interrupt behaviour.
        stepTag = "irq";
        wrReg(4'd8, 16'h0000);
        wrReg(4'd0, 16'h0); wrReg(4'd1, 16'h0); wrReg(4'd2, 16'h0); wrReg(4'd3, 16'h0);
        wrReg(4'd4, 16'h0010); wrReg(4'd5, 16'h0); wrReg(4'd6, 16'h0); wrReg(4'd7, 16'h0);
        wrReg(4'd8, 16'h0003);
        idle(16);
        checkValue("irq not yet", {15'b0, irq_o}, 16'h0000);
        idle(1);
        checkValue("irq rises", {15'b0, irq_o}, 16'h0001);
        rdReg(4'd9);
        checkValue("status", bus.data_o, 16'h0003);
        wrReg(4'd4, 16'hFFFF);
        checkValue("irq lag on cmp write", {15'b0, irq_o}, 16'h0001);
        idle(1);
        checkValue("irq falls on cmp raise", {15'b0, irq_o}, 16'h0000);
        wrReg(4'd4, 16'h0010);
        idle(1);
        checkValue("irq back", {15'b0, irq_o}, 16'h0001);
        wrReg(4'd8, 16'h0001);
        idle(1);
        checkValue("irq falls on IRQ_EN clear", {15'b0, irq_o}, 16'h0000);

        // Write mask and write-over-tick priority.
        stepTag = "mask";
        wrReg(4'd8, 16'h0000);
        wrReg(4'd0, 16'h1200);
        applyStimulus(1, 0, 1, 4'd0, 16'hABCD, 16'h00FF);
        rdReg(4'd0);
        checkValue("masked write", bus.data_o, 16'h12CD);
        wrReg(4'd8, 16'h0001);
        wrReg(4'd0, 16'h5555);
        rdReg(4'd0);
        checkValue("write beats tick", bus.data_o, 16'h5555);

        // Wrap from all-ones and unmapped indices.
        stepTag = "wrap";
        wrReg(4'd8, 16'h0000);
        wrReg(4'd0, 16'hFFFF); wrReg(4'd1, 16'hFFFF); wrReg(4'd2, 16'hFFFF); wrReg(4'd3, 16'hFFFF);
        wrReg(4'd8, 16'h0001);
        wrReg(4'd8, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            rdReg(4'(i));
            checkValue($sformatf("wrap hw%0d", i), bus.data_o, 16'h0000);
        end
        wrReg(4'd12, 16'hFFFF);
        rdReg(4'd12);
        checkValue("unmapped read", bus.data_o, 16'h0000);
        rdReg(4'd8);
        checkValue("ctrl untouched", bus.data_o, 16'h0000);
        rdReg(4'd4);
        checkValue("cmp untouched", bus.data_o, 16'h0010);

        // Randomized traffic against the model, with one reset mid-stream.
        stepTag = "random";
        for (int i = 0; i < 1500; i++) begin
            a   = 4'($urandom_range(0, 15));
            sel = ($urandom_range(0, 9) != 0);
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) == 0);
            d   = 16'($urandom);
            m   = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
            if (a == 4'd8) d[15:8] = 8'($urandom_range(0, 3));
            if (a == 4'd5 || a == 4'd6 || a == 4'd7 || a == 4'd1 || a == 4'd2 || a == 4'd3)
                d = 16'($urandom_range(0, 1));
            applyStimulus(sel, rd, wr, a, d, m);
            if (i == 700) pulseReset("random reset");
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/rv32i_mtimer.md
Name: rv32i_mtimer

Overview:
- Memory-mapped machine timer: the responder end of the core's 16-bit halfword memory port, mapped into one region of the memory map.
- Provides a free-running 64-bit mtime, a 64-bit mtimecmp and a level timer-interrupt output.
- 64-bit values are reached through four halfword registers each; a snapshot makes mtime reads coherent.
- Read timing matches the block RAMs on the same port (registered data, one-cycle latency), so it drops into the existing region mux unchanged.

Parameters:
- PORT_LEN, 16, data port width (fixed at 16; other values unsupported).
- PRESCALE_BITS, 8, width of the prescale field and prescale counter.

Ports:
- clk_i  input  1  system clock.
- reset_ni  input  1  asynchronous active-low reset.
- select_i  input  1  region select from the memory decoder; access ignored when 0.
- read_i  input  1  read strobe, qualified by select_i.
- write_i  input  1  write strobe, qualified by select_i.
- addr_i  input  4  halfword register index (byte address bits [4:1]).
- data_i  input  16  write data.
- write_mask_i  input  16  per-bit write enable; 1 = bit written.
- data_o  output  16  registered read data.
- irq_o  output  1  machine timer interrupt, level, registered.

Behaviour:
- Reset: one clock, asynchronous active-low reset reset_ni. Asserting it at any time, including mid-count or mid-read, immediately forces:
  - mtime = 0, mtimecmp = 0xFFFF_FFFF_FFFF_FFFF;
  - CTRL = 0, prescale counter = 0, snapshot = 0;
  - data_o = 0, irq_o = 0.
- Register map (addr_i):
  - 0–3: mtime halfwords, low to high.
  - 4–7: mtimecmp halfwords, low to high.
  - 8: CTRL. bit0 EN (count enable), bit1 IRQ_EN, bits[15:8] PRESCALE, other bits read 0.
  - 9: STATUS, read-only. bit0 = (mtime >= mtimecmp), bit1 = EN.
  - 10–15: read 0, writes ignored.
- Writes: select_i & write_i at a clock edge sets reg = (reg & ~write_mask_i) | (data_i & write_mask_i).
- Reads, one-cycle latency:
  - select_i & read_i in cycle N sets data_o at the edge ending cycle N; data_o holds until the next read.
  - The value returned is the register content before that edge's updates, so a read together with a write to the same register returns the old value.
- Snapshot:
  - A read of index 0 returns live mtime[15:0] and, at the same edge, latches mtime[63:16] into the snapshot.
  - Reads of indices 1–3 return snapshot halfwords, not live mtime.
  - mtimecmp reads are always live.
- Prescaler:
  - While EN = 1, the prescale counter increments each cycle.
  - When counter == PRESCALE: tick, and the counter returns to 0. PRESCALE = 0 means a tick every cycle; PRESCALE = P means a tick every P+1 cycles.
  - While EN = 0 the counter holds and no ticks occur.
  - Any CTRL write clears the prescale counter.
- Counting:
  - A tick sets mtime = mtime + 1, modulo 2^64; all-ones wraps to 0 with no flag.
  - A write to any mtime halfword takes priority over a tick in the same cycle: the written value is loaded and that tick is dropped.
- Interrupt:
  - irq_o <= IRQ_EN & (mtime >= mtimecmp), unsigned 64-bit compare, registered, so it lags the state by one cycle.
  - There is no sticky pending bit; software clears the interrupt by raising mtimecmp or clearing IRQ_EN.
  - mtimecmp halfwords take effect individually; transient compares during multi-halfword updates are software's responsibility.
- A strobe with select_i = 0 has no effect. read_i and write_i both asserted: both act as above.

Test Plan:
- Reset: count with EN = 1, PRESCALE = 0, IRQ_EN = 1, mtimecmp = 0; pulse reset_ni low between edges. Required: data_o and irq_o go to 0 immediately; then index 0 reads 0x0000 and index 4 reads 0xFFFF.
- Basic count: write CTRL = 0x0001 in cycle t; read index 0 in cycle t+10 -> 0x0009. Set PRESCALE = 3 (CTRL = 0x0301), clear mtime, run 40 cycles -> reads 0x000A (±1 per the edge rule).
- Snapshot: load mtime = 0x0000_0000_0000_FFFE with EN = 1, PRESCALE = 0; read index 0 -> 0xFFFE; read index 1 five cycles later -> 0x0000 (snapshot), although live mtime[31:16] = 1.
- Compare/IRQ: mtime = 0, mtimecmp = 0x10, CTRL = 0x0003. Required: irq_o rises one cycle after mtime reaches 0x10; STATUS bit0 = 1. Then write index 4 = 0xFFFF: irq_o falls the cycle after that write. Clearing IRQ_EN also drops irq_o.
- Write mask / priority: write index 0 with data 0xABCD and mask 0x00FF over 0x1200 with EN = 0 -> reads 0x12CD. Write mtime during a tick cycle -> the written value is read back with no extra increment.
- Wrap / unmapped: mtime = all-ones, one tick -> all four halfwords read 0x0000. Write 0xFFFF to index 12 -> reads 0; other registers unchanged.
